// File: rtl/dpi_stream_sequencer_if.sv
// Byte stream from the packet parser into the DPI sequencer: handshake, framing and flow key.
interface dpi_stream_sequencer_if #(
  parameter int KEY_W = 32
);
  logic             valid;
  logic             ready;
  logic [7:0]       data;
  logic             sop;
  logic             eop;
  logic [KEY_W-1:0] key;

  modport master (output valid, data, sop, eop, key, input ready);
  modport slave  (input valid, data, sop, eop, key, output ready);
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Flow-keyed front end for the regex matcher bank: maps each packet's key to a stream id and
// sequences load_state / character stream / eop on the matchers' shared control bus.
module dpi_stream_sequencer #(
  parameter int NSTREAM  = 64,
  parameter int SID_W    = 6,
  parameter int KEY_W    = 32,
  parameter int NCAT     = 8,
  parameter int LOAD_GAP = 3,
  parameter int DRAIN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dpi_stream_sequencer_if.slave s,
  input  logic                  flush,
  input  logic                  cfg_wr,
  input  logic [SID_W-1:0]      cfg_sid,
  input  logic [NCAT-1:0]       cfg_mask,
  input  logic [NCAT-1:0]       cfg_default_mask,
  output logic                  load_state,
  output logic [SID_W-1:0]      stream_id,
  output logic                  new_stream_id,
  output logic [7:0]            char_in,
  output logic                  char_in_vld,
  output logic                  eop,
  output logic [NCAT-1:0]       enable,
  output logic                  table_full,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count
);

  // The FSM follows the input side. Outputs are registered from the next state, so the
  // character stream is accepted one cycle before it appears on char_in_vld; GAP therefore
  // spans LOAD_GAP-2 cycles and DRAIN spans DRAIN cycles. LOAD_GAP >= 2, DRAIN >= 1.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] GAP_INIT   = (LOAD_GAP > 2) ? CNT_W'(LOAD_GAP - 3) : '0;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_LOAD, ST_GAP, ST_STREAM, ST_DRAIN, ST_EOP, ST_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q;
  logic [SID_W-1:0]   sid_q;
  logic               flush_pend_q;
  logic               flush_now;
  logic               ready_q, ready_d;
  logic               xfer;

  logic [NSTREAM-1:0] valid_q;
  logic [KEY_W-1:0]   key_tab [NSTREAM];
  logic [NCAT-1:0]    mask_q  [NSTREAM];

  logic               hit, free_found, alloc;
  logic [SID_W-1:0]   hit_idx, free_idx, sid_sel;

  assign s.ready    = ready_q;
  assign xfer       = s.valid && ready_q;
  assign table_full = &valid_q;

  // Keys are unique in the table, so at most one entry hits; the free search favours low indices.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NSTREAM - 1; i >= 0; i--) begin
      if (valid_q[i] && key_tab[i] == key_q) begin
        hit     = 1'b1;
        hit_idx = SID_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = SID_W'(i);
      end
    end
  end

  assign sid_sel = hit ? hit_idx : free_idx;
  assign alloc   = (state_q == ST_LOOKUP) && !hit && free_found;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flush_now = flush || flush_pend_q;
        if (s.valid && s.sop && !ready_q) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: state_d = (hit || free_found) ? ST_LOAD : ST_DROP;
      ST_LOAD: begin
        if (LOAD_GAP > 2) begin
          state_d = ST_GAP;
          cnt_d   = GAP_INIT;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_STREAM;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_STREAM: begin
        if (xfer && s.eop) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_EOP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_EOP:  state_d = ST_IDLE;
      ST_DROP: if (xfer && s.eop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stray non-sop bytes in IDLE are acked for one cycle only, since the next byte is unseen.
  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      ST_STREAM, ST_DROP: ready_d = 1'b1;
      ST_IDLE:            ready_d = s.valid && !s.sop && !ready_q;
      default:            ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      sid_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= (flush_pend_q || flush) && !flush_now;
      if (state_q == ST_IDLE && state_d == ST_LOOKUP) key_q <= s.key;
      if (state_q == ST_LOOKUP) sid_q <= sid_sel;
    end
  end

  // NOTE: valid bits and masks must come up cleared; key storage is only read behind a valid bit, so it stays unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NSTREAM; i++) mask_q[i] <= '0;
    end else begin
      if (flush_now) valid_q <= '0;
      if (alloc) begin
        valid_q[free_idx] <= 1'b1;
        mask_q[free_idx]  <= cfg_default_mask;
      end
      // Later assignment wins, so a colliding configuration write overrides the default mask.
      if (cfg_wr) mask_q[cfg_sid] <= cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) key_tab[free_idx] <= key_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      load_state    <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      enable        <= '0;
      pkt_count     <= '0;
      drop_count    <= '0;
    end else begin
      ready_q       <= ready_d;
      load_state    <= (state_d == ST_LOAD);
      new_stream_id <= (state_d == ST_LOAD) && !hit;
      if (state_d == ST_LOAD) stream_id <= sid_sel;
      char_in_vld   <= (state_q == ST_STREAM) && xfer;
      if (state_q == ST_STREAM && xfer) char_in <= s.data;
      eop           <= (state_d == ST_EOP);
      enable        <= (state_d == ST_EOP) ? mask_q[sid_q] : '0;
      if (state_d == ST_EOP) pkt_count <= pkt_count + 16'd1;
      if (state_q == ST_LOOKUP && state_d == ST_DROP && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule
